// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Unsigned sequential divider using restoring shift-subtract division. It
//   produces one quotient bit per clock, MSB first, so an operation takes
//   exactly N cycles. Results are registered and hold steady until the next
//   operation completes.
//
// Ports
//   clock        in   sole clock, rising edge
//   n_reset      in   asynchronous active-low reset
//   start        in   begin a division; only sampled while ready=1
//   ready        out  1 = idle and accepting start, 0 = division in progress
//   dividend     in   [N-1:0] unsigned numerator, sampled on the accepting edge
//   divisor      in   [N-1:0] unsigned denominator, sampled on the accepting edge
//   quotient     out  [N-1:0] quotient of the last completed division
//   remainder    out  [N-1:0] remainder of the last completed division
//   div_by_zero  out  1 when the last completed division had divisor = 0
// -----------------------------------------------------------------------------
module divider #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         start,
    output logic         ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Working registers
    logic          state_q,   state_d;
    logic [N:0]    prem_q,    prem_d;     // partial remainder
    logic [N-1:0]  qsh_q,     qsh_d;      // quotient shift register
    logic [N-1:0]  dvs_q,     dvs_d;      // latched divisor
    logic [CW-1:0] cnt_q,     cnt_d;      // iterations left

    // Result registers
    logic [N-1:0]  quotient_q,  quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q,       dbz_d;

    // One iteration of the datapath
    logic [N+1:0]  shifted;
    logic [N+1:0]  trial;
    logic          negative;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        prem_d      = prem_q;
        qsh_d       = qsh_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        // Shift the remainder left, pulling in the next dividend bit from the
        // top of the quotient register. The partial remainder is always below
        // the divisor, so one extra bit is enough to keep the sign honest.
        shifted  = {prem_q, qsh_q[N-1]};
        trial    = shifted - {2'b00, dvs_q};
        negative = trial[N+1];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    prem_d  = '0;
                    qsh_d   = dividend;
                    dvs_d   = divisor;
                    cnt_d   = CW'(N);
                end
            end
            default: begin
                // Restore on a negative trial; otherwise keep the difference.
                // A zero divisor never goes negative, which naturally yields
                // an all-ones quotient and remainder equal to the dividend.
                prem_d = negative ? shifted[N:0] : trial[N:0];
                qsh_d  = N'({qsh_q, ~negative});
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = ST_IDLE;
                    quotient_d  = qsh_d;
                    remainder_d = prem_d[N-1:0];
                    dbz_d       = (dvs_q == '0);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clock or negedge n_reset) begin
        // NOTE: all registers here are plain flops (no memory arrays), so
        // every one of them is cleared by reset.
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            prem_q      <= '0;
            qsh_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prem_q      <= prem_d;
            qsh_q       <= qsh_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Directed self-checking bench for divider with N = 4. Outputs are sampled
//   1 ns after the rising edge; inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_divider;

    localparam int N = 4;

    logic         clock;
    logic         n_reset;
    logic         start;
    logic         ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    divider #(.N(N)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .start       (start),
        .ready       (ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch one division, confirm the latency, that the previous result
    // holds throughout BUSY, and the final result. Operands are scrambled
    // during BUSY to prove they are not re-sampled.
    task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz);
        logic [N-1:0] pq, pr;
        logic         pd;
        int           lat;
        bit           stable;
        @(negedge clock);
        check({tag, " ready_before"}, 32'(ready), 32'd1);
        pq = quotient; pr = remainder; pd = div_by_zero;
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        dividend = N'($urandom); divisor = N'($urandom);
        lat = 0; stable = 1'b1;
        while (ready !== 1'b1 && lat < 20) begin
            if (quotient !== pq || remainder !== pr || div_by_zero !== pd) stable = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(N));
        check({tag, " hold_during_busy"}, 32'(stable), 32'd1);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    endtask

    initial begin
        logic [N-1:0] hq, hr;
        logic         hd;
        int           lat;

        n_reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset ready", 32'(ready), 32'd1);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);

        // Release shortly after an edge; the first division is then accepted
        // on the very first rising edge after reset deasserts.
        #1 n_reset = 1'b1;
        run_div("13/4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0);

        // Idle with start low: nothing moves
        hq = quotient; hr = remainder; hd = div_by_zero;
        repeat (3) @(posedge clock);
        #1;
        check("idle ready", 32'(ready), 32'd1);
        check("idle quotient", 32'(quotient), 32'(hq));
        check("idle remainder", 32'(remainder), 32'(hr));
        check("idle dbz", 32'(div_by_zero), 32'(hd));

        run_div("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        run_div("3/9",  4'd3,  4'd9, 4'd0,  4'd3, 1'b0);
        run_div("0/5",  4'd0,  4'd5, 4'd0,  4'd0, 1'b0);
        run_div("7/0",  4'd7,  4'd0, 4'd15, 4'd7, 1'b1);
        run_div("6/3",  4'd6,  4'd3, 4'd2,  4'd0, 1'b0);

        // start held high through BUSY with new operands
        @(negedge clock);
        dividend = 4'd13; divisor = 4'd4; start = 1'b1;
        @(posedge clock); #1;
        dividend = 4'd9; divisor = 4'd2;
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check("held_start first latency", 32'(lat), 32'(N));
        check("held_start first quotient", 32'(quotient), 32'd3);
        check("held_start first remainder", 32'(remainder), 32'd1);
        @(posedge clock); #1;
        check("held_start second accepted", 32'(ready), 32'd0);
        start = 1'b0;
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check("held_start second latency", 32'(lat), 32'(N));
        check("held_start second quotient", 32'(quotient), 32'd4);
        check("held_start second remainder", 32'(remainder), 32'd1);

        // Reset in the middle of a division
        run_div("13/4 pre_reset", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
        @(negedge clock);
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_reset = 1'b0;
        #1;
        check("midreset ready", 32'(ready), 32'd1);
        check("midreset quotient", 32'(quotient), 32'd0);
        check("midreset remainder", 32'(remainder), 32'd0);
        check("midreset dbz", 32'(div_by_zero), 32'd0);
        @(posedge clock); #1;
        check("midreset held quotient", 32'(quotient), 32'd0);
        check("midreset held remainder", 32'(remainder), 32'd0);
        #1 n_reset = 1'b1;
        run_div("14/3 after reset", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0);

        // Every operand pair
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [N-1:0] eq, er;
                if (b == 0) begin
                    eq = 4'd15;
                    er = N'(a);
                end else begin
                    eq = N'(a / b);
                    er = N'(a % b);
                end
                run_div($sformatf("ex %0d/%0d", a, b), N'(a), N'(b), eq, er, b == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter N, default 4: width in bits of the dividend, divisor, quotient and remainder.
REQ-002 clock  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 n_reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  request to begin a division; sampled only on a rising edge where ready=1.
REQ-005 ready  output  1  high when idle and able to accept start; low while a division is in progress.
REQ-006 dividend  input  N  unsigned numerator; sampled on the accepting edge only.
REQ-007 divisor  input  N  unsigned denominator; sampled on the accepting edge only.
REQ-008 quotient  output  N  unsigned quotient of the most recently completed division.
REQ-009 remainder  output  N  unsigned remainder of the most recently completed division.
REQ-010 div_by_zero  output  1  high when the most recently completed division had divisor=0.

Function
REQ-011 Algorithm SHALL be restoring shift-subtract division producing one quotient bit per cycle, MSB first.
REQ-012 Working state: partial remainder of N+1 bits, quotient shift register of N bits, latched divisor of N bits, iteration counter of ceil(log2(N+1)) bits.
REQ-013 States: IDLE (ready=1) and BUSY (ready=0); no other states.
REQ-014 IDLE -> BUSY on a rising edge with start=1; on that edge: latch divisor, load dividend into the quotient shift register, clear partial remainder, preset counter to N.
REQ-015 start=0 in IDLE: no state change; outputs hold.
REQ-016 Each BUSY edge: shift {partial remainder, quotient register} left 1; trial-subtract divisor from the upper N+1 bits; if the result is non-negative, keep it and set the new quotient LSB=1, else restore and set LSB=0; decrement counter.
REQ-017 BUSY lasts exactly N edges; on the edge the counter reaches zero, the state returns to IDLE and quotient, remainder and div_by_zero update simultaneously.
REQ-018 Latency: ready low for exactly N cycles after the accepting edge; results valid from the edge ready rises.
REQ-019 quotient, remainder and div_by_zero SHALL hold the previous result, unchanged, throughout BUSY.
REQ-020 start during BUSY SHALL be ignored and SHALL NOT extend or restart the operation; dividend/divisor changes during BUSY SHALL have no effect.
REQ-021 Minimum spacing: a new start SHALL be accepted no earlier than the first edge after ready rises (at least one IDLE cycle between operations).
REQ-022 divisor=0: latency unchanged (N cycles); quotient = all ones (2^N-1), remainder = dividend, div_by_zero=1.
REQ-023 divisor>dividend: quotient=0, remainder=dividend, div_by_zero=0.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every divisor != 0.

Reset
REQ-025 n_reset=0 SHALL immediately force IDLE, ready=1, quotient=0, remainder=0, div_by_zero=0, and clear all working registers and the counter.
REQ-026 Reset during BUSY SHALL abandon the operation; no partial result SHALL appear on the outputs.
REQ-027 After n_reset deasserts, start SHALL be accepted on the first rising edge.

Verification
REQ-028 N=4, dividend=13, divisor=4, start for 1 cycle -> ready low exactly 4 cycles; then quotient=3, remainder=1, div_by_zero=0.
REQ-029 N=4: 15/1 -> q=15, r=0; 3/9 -> q=0, r=3; 0/5 -> q=0, r=0; each with 4-cycle latency.
REQ-030 N=4, dividend=7, divisor=0 -> after 4 cycles q=15, r=7, div_by_zero=1; next 6/3 -> q=2, r=0, div_by_zero=0.
REQ-031 Start 13/4, then hold start=1 with operands 9/2 for the whole BUSY period -> first result q=3, r=1; 9/2 accepted only on the edge after ready rises, giving q=4, r=1.
REQ-032 Complete 13/4, start 14/3, assert n_reset for 1 cycle at BUSY cycle 2 -> ready=1, q=0, r=0 immediately; no 14/3 result appears; a fresh 14/3 then gives q=4, r=2.
REQ-033 Exhaustive N=4: all 256 operand pairs checked against REQ-022 and REQ-024; outputs stable during every BUSY period.
